// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: sequences loads, word stores and sub-word read-modify-write
// stores onto a word-only RAM. Define DMEM_RMW_CNT_EN to add the rmw_cnt completed-RMW counter.
module dmem_access_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
`ifdef DMEM_RMW_CNT_EN
  output logic [15:0]       rmw_cnt,
`endif
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {IDLE, RD, MRG, WR, RESP} state_t;

  state_t      state;
  logic        we_q, sgn_q;
  logic [1:0]  size_q, off_q;
  logic [31:0] wdata_q;
  logic        bad;

  always_comb begin
    bad = (req_size == 2'b11)
        | ((req_size == SZ_H) & req_addr[0])
        | ((req_size == SZ_W) & (|req_addr[1:0]))
        | ((req_addr >> (ADDR_W + 2)) != 32'd0);
  end

  // Byte lanes touched by a store; every other lane keeps the value read in RD.
  logic [3:0] lane_sel;
  always_comb begin
    lane_sel = 4'b1111;
    case (size_q)
      SZ_B:    lane_sel = 4'b0001 << off_q;
      SZ_H:    lane_sel = off_q[1] ? 4'b1100 : 4'b0011;
      default: lane_sel = 4'b1111;
    endcase
  end

  logic [3:0][7:0] rd_lanes, wr_lanes, merged;
  assign rd_lanes = mem_rdata;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    // Store data is right-aligned, so a byte replicates to all lanes and a half to both halves.
    assign wr_lanes[i] = (size_q == SZ_B) ? wdata_q[7:0] :
                         (size_q == SZ_H) ? wdata_q[8*(i%2) +: 8] :
                                            wdata_q[8*i +: 8];
    assign merged[i]   = lane_sel[i] ? wr_lanes[i] : rd_lanes[i];
  end

  logic [31:0] shifted, ld_data;
  assign shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      SZ_B:    ld_data = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
      SZ_H:    ld_data = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      we_q       <= 1'b0;
      sgn_q      <= 1'b0;
      size_q     <= '0;
      off_q      <= '0;
      wdata_q    <= '0;
`ifdef DMEM_RMW_CNT_EN
      rmw_cnt    <= '0;
`endif
    end else begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          we_q      <= req_we;
          sgn_q     <= req_signed;
          size_q    <= req_size;
          off_q     <= req_addr[1:0];
          wdata_q   <= req_wdata;
          req_ready <= 1'b0;
          if (bad) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else if (req_we && req_size == SZ_W) begin
            state     <= WR;
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= req_addr[ADDR_W+1:2];
            mem_wdata <= req_wdata;
          end else begin
            state    <= RD;
            mem_en   <= 1'b1;
            mem_addr <= req_addr[ADDR_W+1:2];
          end
        end
        RD: state <= MRG;
        MRG: if (we_q) begin
          state     <= WR;
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_wdata <= merged;
        end else begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= ld_data;
        end
        WR: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
`ifdef DMEM_RMW_CNT_EN
          if (size_q != SZ_W && rmw_cnt != 16'hFFFF) rmw_cnt <= rmw_cnt + 16'd1;
`endif
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: directed requests push expected responses,
// a negedge monitor pops and compares them, and a 1-cycle RAM model tracks writes.
module tb_dmem_access_ctrl;

  localparam int ADDR_W = 12;

  logic              clk, reset_n;
  logic              req_valid, req_ready, req_we, req_signed;
  logic [1:0]        req_size;
  logic [31:0]       req_addr, req_wdata;
  logic              resp_valid, resp_err;
  logic [31:0]       resp_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
`ifdef DMEM_RMW_CNT_EN
  logic [15:0]       rmw_cnt;
`endif

  dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef DMEM_RMW_CNT_EN
    .rmw_cnt(rmw_cnt),
`endif
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: one-cycle read latency, word0 preloaded
  logic [31:0] ram [0:15];
  logic        ram_init = 1'b0;
  int          nwr = 0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 16; i++) ram[i] <= (i == 0) ? 32'h11223344 : 32'h0;
      ram_init <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr[3:0]] <= mem_wdata;
        nwr <= nwr + 1;
      end else begin
        mem_rdata <= ram[mem_addr[3:0]];
      end
    end
  end

  int n_cmp = 0, n_bad = 0, n_men = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  always @(negedge clk) if (mem_en) n_men++;

  always @(negedge clk) begin
    if (reset_n && resp_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got resp_valid at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("resp_err", resp_err, e.err);
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  // lat = cycles from accept to resp_valid; acc = index of the accepting clock edge
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic push,
                       input logic e_err, input logic [31:0] e_rd, input int lat,
                       output int acc);
    int n;
    n = 0;
    @(negedge clk);
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got no req_ready within 40 cycles expected accept");
      acc = -1;
      req_valid = 1'b0;
    end else begin
      acc = cyc + 1;
      if (push) sbq.push_back('{e_err, e_rd, acc + lat - 1});
      @(posedge clk);
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int e1, e2, w0, m0;
    reset_n = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {req_ready, resp_valid, resp_err, mem_en, mem_we}, 5'b10000);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_maddr", mem_addr, '0);
    chk("rst_mwdata", mem_wdata, 32'h0);
    @(negedge clk) reset_n = 1'b1;

    // sw word1
    w0 = nwr;
    issue(1'b1, 2'b10, 1'b0, 32'h4, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 2, e1);
    drain();
    chk("sw_word1", ram[1], 32'hDEADBEEF);
    chk("sw_nwr", nwr - w0, 1);

    // sb into byte 2 of word0
    w0 = nwr;
    issue(1'b1, 2'b00, 1'b0, 32'h2, 32'h000000AB, 1'b1, 1'b0, 32'h0, 4, e1);
    drain();
    chk("sb_word0", ram[0], 32'h11AB3344);
    chk("sb_nwr", nwr - w0, 1);
`ifdef DMEM_RMW_CNT_EN
    chk("rmw_cnt1", rmw_cnt, 16'd1);
`endif

    // loads with sign/zero extension
    issue(1'b0, 2'b00, 1'b1, 32'h2, 32'h0, 1'b1, 1'b0, 32'hFFFFFFAB, 3, e1);
    issue(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 1'b1, 1'b0, 32'h000011AB, 3, e1);
    issue(1'b0, 2'b00, 1'b0, 32'h3, 32'h0, 1'b1, 1'b0, 32'h00000011, 3, e1);
    drain();

    // sh upper half of word1, then read it back
    issue(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000CAFE, 1'b1, 1'b0, 32'h0, 4, e1);
    issue(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 1'b1, 1'b0, 32'hFFFFCAFE, 3, e1);
    issue(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 1'b1, 1'b0, 32'h000000CA, 3, e1);
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h11AB3344, 3, e1);
    drain();
    chk("sh_word1", ram[1], 32'hCAFEBEEF);
`ifdef DMEM_RMW_CNT_EN
    chk("rmw_cnt2", rmw_cnt, 16'd2);
`endif

    // error cases: no RAM traffic
    w0 = nwr; m0 = n_men;
    issue(1'b1, 2'b01, 1'b0, 32'h1, 32'h1234, 1'b1, 1'b1, 32'h0, 1, e1);
    issue(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 1'b1, 1'b1, 32'h0, 1, e1);
    issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1, e1);
    issue(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 1'b1, 1'b1, 32'h0, 1, e1);
    drain();
    chk("err_men", n_men - m0, 0);
    chk("err_nwr", nwr - w0, 0);
    chk("err_word0", ram[0], 32'h11AB3344);

    // reset during MRG of a sub-word store
    w0 = nwr;
    issue(1'b1, 2'b00, 1'b0, 32'h1, 32'h00000055, 1'b0, 1'b0, 32'h0, 4, e1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_ctrl", {req_ready, resp_valid, resp_err, mem_en, mem_we}, 5'b10000);
    chk("abort_rdata", resp_rdata, 32'h0);
    chk("abort_mwdata", mem_wdata, 32'h0);
`ifdef DMEM_RMW_CNT_EN
    chk("abort_rmw_cnt", rmw_cnt, 16'd0);
`endif
    @(negedge clk) reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_nwr", nwr - w0, 0);
    chk("abort_word0", ram[0], 32'h11AB3344);

    // back-to-back: second request waits with req_valid held
    w0 = nwr;
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'hCAFEBEEF, 3, e1);
    issue(1'b1, 2'b10, 1'b0, 32'h8, 32'h12345678, 1'b1, 1'b0, 32'h0, 2, e2);
    drain();
    chk("b2b_accept", e2, e1 + 4);
    chk("b2b_word2", ram[2], 32'h12345678);
    chk("b2b_nwr", nwr - w0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000 expected earlier");
    $fatal(1, "timeout");
  end

endmodule
